arb8_decoder_ctrl: RTL
======================

# arb8_decoder_ctrl

Round-robin arbiter and sequencer that shares one active-low 3-to-8 select decoder among eight requesters. It picks one requester at a time and holds the grant until the owner releases it or a tenure limit expires. It drives the grant as a 3-bit index plus an active-low one-hot select. It sits between the requesting agents and the shared select decoder, and is the only block that drives that decoder's address and enable.

## Interface
- `MAX_HOLD`, default 16: maximum grant tenure in cycles (range 2..255).
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req`, in, 8: request per agent; level-sensitive; bit i belongs to agent i.
- `done`, in, 1: release pulse from the current owner; ignored when no grant is active.
- `grant_idx`, out, 3: index of the current owner; valid only while `grant_valid` = 1.
- `grant_n`, out, 8: active-low one-hot select; bit `grant_idx` is 0 during a grant, all bits are 1 otherwise.
- `grant_valid`, out, 1: a grant is active.
- `preempt`, out, 1: one-cycle pulse in the cycle after a grant ends by tenure expiry.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: an owner holds the select.
  - GAP: one dead cycle after every release.
- Round-robin pointer `ptr`, 3 bits:
  - The search starts at `ptr` and wraps 7→0.
  - The first set `req` bit wins.
  - On a grant to index k, `ptr` becomes (k+1) mod 8.
- IDLE → GRANT when any `req` bit is set. The winner is latched into `grant_idx`, and the hold counter is cleared to 0.
- GRANT → GAP on the first of these conditions:
  - `done` = 1.
  - `req[grant_idx]` = 0, i.e. the owner dropped its request.
  - The hold counter reaches `MAX_HOLD`-1. In this case `preempt` pulses in the GAP cycle.
- In GRANT, the hold counter increments once per cycle and saturates at `MAX_HOLD`-1.
- If `done` and tenure expiry occur in the same cycle, it counts as a normal release and `preempt` stays 0.
- GAP → GRANT if any `req` bit is set, with a fresh arbitration from `ptr`. Otherwise GAP → IDLE.
- The previous owner may win again only if no other `req` bit is set.
- Changes to `req` during GRANT do not change the owner.
- Hold counter width is clog2(`MAX_HOLD`). It never wraps.
- Reset values, applied immediately on `rst_n` falling:
  - state = IDLE
  - `ptr` = 0
  - `grant_idx` = 0
  - `grant_n` = 8'hFF
  - `grant_valid` = 0
  - `preempt` = 0
  - hold counter = 0
- A reset in mid-grant drops the grant in the same instant. The grant is never resumed.

## Timing
- All outputs are registered, with no combinational path from the inputs.
- Request-to-grant latency is 1 cycle: `req` set before edge t gives `grant_valid` = 1 after edge t.
- The release condition is sampled at edge t; `grant_valid` = 0 and `grant_n` = FF after edge t. The earliest next grant appears after edge t+1.
- `grant_n`, `grant_idx` and `grant_valid` change on the same edge, so there is never a glitch with two zeros in `grant_n`.
- Maximum tenure is `MAX_HOLD` cycles of `grant_valid` = 1.
- Under full load, each agent waits at most 7×(`MAX_HOLD`+1) cycles.
- Reset deassertion is synchronised externally. The first evaluation happens on the first edge after `rst_n` rises.

## Structure
- Package `arb8_pkg` holds:
  - `N_REQ` = 8
  - `IDX_W` = 3
  - the state enum (IDLE, GRANT, GAP)
  - a round-robin priority-pick function (req, ptr) → (found, idx).
- Submodule `dec3to8_n`:
  - Combinational active-low decoder with inputs idx[2:0] and en.
  - It decodes the next-state index and enable.
  - Its output is registered into `grant_n` in the parent.
- Expected size of the parent: FSM, pointer, hold counter and output registers, about 150–250 lines.

## Test plan
- Single requester, with `req` = 8'h04 held and `done` pulsed on the 3rd grant cycle:
  - `grant_valid` 1 cycle after `req`; `grant_idx` = 2; `grant_n` = 8'hFB.
  - After the release: one GAP cycle with FF, then a re-grant to index 2.
- Round-robin fairness with `req` = 8'hFF and `done` pulsed every grant:
  - Grant order is 0,1,…,7,0.
  - There is one FF cycle between consecutive grants.
- Tenure expiry with `MAX_HOLD` = 4, `req` = 8'h81 and no `done`:
  - Index 0 is held exactly 4 cycles, then `preempt` = 1 for 1 cycle.
  - The next grant goes to index 7 (`grant_n` = 8'h7F), then back to 0.
- Owner drops its request, with `req` going 8'h02 → 8'h00 in mid-grant:
  - Release after the next edge.
  - Then GAP → IDLE; `grant_n` stays FF.
- Simultaneous `done` and expiry with `MAX_HOLD` = 4, `done` in the 4th cycle:
  - Release occurs; `preempt` = 0.
- Reset mid-grant, with `rst_n` low asynchronously during a grant to index 5:
  - `grant_n` = FF and `grant_valid` = 0 immediately, without waiting for a clock edge.
  - After release of reset with `req` = 8'h21, the next grant goes to index 0 because `ptr` was reset to 0.

Source files
------------

// File: rtl/arb8_pkg.sv
// arb8_pkg: shared constants, FSM state type and round-robin pick for arb8_decoder_ctrl
// Contents: N_REQ/IDX_W sizes, state_e (IDLE/GRANT/GAP), pick_t result and rr_pick(req, ptr).
package arb8_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Scanned from the highest offset down so the lowest offset from ptr wins.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [IDX_W-1:0] ptr);
        pick_t            r;
        logic [IDX_W-1:0] k;
        r = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = ptr + IDX_W'(i);
            if (req[k]) r = '{found: 1'b1, idx: k};
        end
        return r;
    endfunction
endpackage

// File: rtl/arb8_decoder_ctrl_dec.sv
// dec3to8_n: combinational active-low 3-to-8 select decoder
// Ports: idx_i[2:0] select index, en_i enable, y_o[7:0] active-low one-hot (all ones when disabled).
module dec3to8_n
    import arb8_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] y_o
);
    assign y_o = en_i ? ~(N_REQ'(1) << idx_i) : {N_REQ{1'b1}};
endmodule

// File: rtl/arb8_decoder_ctrl.sv
// arb8_decoder_ctrl: round-robin arbiter sharing one active-low 3-to-8 select among eight requesters
// Ports: clk, rst_n (async active-low), req_i[7:0] level requests, done_i owner release pulse,
//        grant_idx_o[2:0] owner index, grant_n_o[7:0] active-low one-hot select,
//        grant_valid_o grant active, preempt_o one-cycle pulse after a tenure-expiry release.
module arb8_decoder_ctrl
    import arb8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    input  logic             done_i,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic [N_REQ-1:0] grant_n_o,
    output logic             grant_valid_o,
    output logic             preempt_o
);
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              valid_q, en_d;
    logic              preempt_q, preempt_d;
    logic [N_REQ-1:0]  grant_n_q, grant_n_d;
    pick_t             pick;
    logic              expire, rel;

    always_comb begin
        pick      = rr_pick(req_i, ptr_q);
        expire    = hold_q == HOLD_LAST;
        rel       = done_i || !req_i[idx_q] || expire;
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        en_d      = 1'b0;
        preempt_d = 1'b0;
        case (state_q)
            GRANT: begin
                if (rel) begin
                    state_d   = GAP;
                    // done and a dropped request both take precedence over expiry
                    preempt_d = expire && !done_i && req_i[idx_q];
                end else begin
                    en_d   = 1'b1;
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = pick.found ? GRANT : IDLE;
                if (pick.found) begin
                    idx_d  = pick.idx;
                    ptr_d  = pick.idx + IDX_W'(1);
                    hold_d = '0;
                    en_d   = 1'b1;
                end
            end
        endcase
    end

    // Decoding the next-state index lets grant_n share an edge with grant_idx/grant_valid.
    dec3to8_n u_dec (
        .idx_i (idx_d),
        .en_i  (en_d),
        .y_o   (grant_n_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
            grant_n_q <= {N_REQ{1'b1}};
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            valid_q   <= en_d;
            preempt_q <= preempt_d;
            grant_n_q <= grant_n_d;
        end
    end

    assign grant_idx_o   = idx_q;
    assign grant_n_o     = grant_n_q;
    assign grant_valid_o = valid_q;
    assign preempt_o     = preempt_q;
endmodule
